// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port RAM arbiter: FSM state encoding and port indices.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  localparam int PORT_CPU = 0;
  localparam int PORT_LDR = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins; on a tie the port that
// was not served last wins. Purely combinational, one-hot (or zero) result.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);

  always_comb begin
    pick = req;
    if (req == 2'b11) begin
      pick = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one RAM between the cpu (port 0) and the loader
// (port 1). Each grant runs IDLE->ACCESS->DONE; ack pulses in DONE with rdata.
//
//   state  | meaning
//   IDLE   | waiting for a request; winner's address/data/we latched on grant
//   ACCESS | memory cycle; mem_we high for writes, rdata captured at the end
//   DONE   | owner's ack high, rdata stable; last updated, grant released
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic [1:0]    gnt,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_t    state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    ack_q, ack_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          mem_we_q, mem_we_d;
  logic          last_q, last_d;
  logic [1:0]    pick;

  rr_arb2 u_pick (
    .req  ({req1, req0}),
    .last (last_q),
    .pick (pick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_q    <= 2'b00;
      ack_q    <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      mem_we_q <= 1'b0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      mem_we_q <= mem_we_d;
      last_q   <= last_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ack_d    = 2'b00;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    mem_we_d = 1'b0;
    last_d   = last_q;
    unique case (state_q)
      IDLE: begin
        if (pick != 2'b00) begin
          gnt_d   = pick;
          state_d = ACCESS;
          if (pick[PORT_LDR]) begin
            addr_d   = addr1;
            wdata_d  = wdata1;
            mem_we_d = we1;
          end else begin
            addr_d   = addr0;
            wdata_d  = wdata0;
            mem_we_d = we0;
          end
        end
      end
      ACCESS: begin
        // Read data is captured for writes too (returns the pre-write contents).
        rdata_d = mem_rdata;
        ack_d   = gnt_q;
        state_d = DONE;
      end
      DONE: begin
        last_d  = gnt_q[PORT_LDR];
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  assign ack0      = ack_q[PORT_CPU];
  assign ack1      = ack_q[PORT_LDR];
  assign gnt       = gnt_q;
  assign rdata     = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter: behavioural RAM, directed scenarios and
// randomized traffic on disjoint address halves checked against a memory model.
module tb_mem_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [7:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic       ack0, ack1, mem_we;
  logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0] gnt;

  logic [7:0] ram     [256];
  logic [7:0] ref_mem [256];
  logic [7:0] exp0_q[$];
  logic [7:0] exp1_q[$];
  int         ack_log[$];
  int         total = 0;
  int         bad = 0;
  int         we_cnt = 0;

  mem_arbiter #(.AW(8), .DW(8)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .gnt(gnt),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  assign mem_rdata = ram[mem_addr];
  always @(posedge clock) if (mem_we) ram[mem_addr] <= mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every ack pops the owner's expected read data.
  always @(negedge clock) begin
    if (mem_we) we_cnt++;
    chk("ack_exclusive", 32'(ack0 & ack1), 32'd0);
    if (ack0) begin
      ack_log.push_back(0);
      if (exp0_q.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_ack0: got ack want none");
      end else chk("rdata_p0", 32'(rdata), 32'(exp0_q.pop_front()));
    end
    if (ack1) begin
      ack_log.push_back(1);
      if (exp1_q.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_ack1: got ack want none");
      end else chk("rdata_p1", 32'(rdata), 32'(exp1_q.pop_front()));
    end
  end

  task automatic cyc();
    @(posedge clock); #1;
  endtask

  task automatic push_exp(input int port, input logic we, input logic [7:0] a, input logic [7:0] wd);
    if (port == 0) exp0_q.push_back(ref_mem[a]);
    else           exp1_q.push_back(ref_mem[a]);
    if (we) ref_mem[a] = wd;
  endtask

  // One transaction from a port; n = number of cycles from issue to the ack cycle inclusive.
  task automatic xact(input int port, input logic we, input logic [7:0] a,
                      input logic [7:0] wd, output int n);
    push_exp(port, we, a, wd);
    if (port == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd; end
    else           begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd; end
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(port == 0 ? ack0 : ack1) && n < 20);
    chk($sformatf("latency_bound_p%0d", port), 32'(n <= 6), 32'd1);
    cyc();
    if (port == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic rand_port(input int port, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      int n;
      int gap;
      logic [7:0] a;
      a = {port[0], 7'($urandom_range(0, 127))};
      xact(port, 1'($urandom_range(0, 1)), a, 8'($urandom), n);
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        repeat (gap) @(posedge clock);
        #1;
      end
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clock);
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, na, nb, c;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[8'hF3] = 8'h11; ref_mem[8'hF3] = 8'h11;
    ram[8'hF2] = 8'h5A; ref_mem[8'hF2] = 8'h5A;
    ram[8'h00] = 8'hA5; ref_mem[8'h00] = 8'hA5;
    ram[8'hFF] = 8'hC3; ref_mem[8'hFF] = 8'hC3;

    // Reset values
    @(negedge clock);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_ack0", 32'(ack0), 0);
    chk("rst_ack1", 32'(ack1), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_rdata", 32'(rdata), 0);
    cyc();
    reset = 1'b0;

    // Reset mid-ACCESS of a write: no commit, no ack
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'hF3; wdata0 = 8'h77;
    @(negedge clock);
    @(negedge clock);
    chk("A_mem_we_access", 32'(mem_we), 1);
    chk("A_mem_addr", 32'(mem_addr), 32'hF3);
    #1 reset = 1'b1;
    #1;
    chk("A_mem_we_async", 32'(mem_we), 0);
    chk("A_gnt_async", 32'(gnt), 0);
    cyc();
    chk("A_no_ack", 32'(ack0), 0);
    req0 = 1'b0; we0 = 1'b0;
    @(negedge clock);
    chk("A_ram_unchanged", 32'(ram[8'hF3]), 32'h11);
    cyc();
    reset = 1'b0;

    // Port 0 read of 0xF2, cycle-accurate
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'hF2;
    push_exp(0, 1'b0, 8'hF2, 8'h00);
    @(negedge clock);
    chk("B_gnt_c1", 32'(gnt), 0);
    chk("B_ack_c1", 32'(ack0), 0);
    @(negedge clock);
    chk("B_gnt_c2", 32'(gnt), 1);
    chk("B_addr_c2", 32'(mem_addr), 32'hF2);
    chk("B_ack_c2", 32'(ack0), 0);
    chk("B_we_c2", 32'(mem_we), 0);
    @(negedge clock);
    chk("B_gnt_c3", 32'(gnt), 1);
    chk("B_ack_c3", 32'(ack0), 1);
    chk("B_rdata_c3", 32'(rdata), 32'h5A);
    cyc();
    req0 = 1'b0;
    @(negedge clock);
    chk("B_ack_c4", 32'(ack0), 0);
    chk("B_gnt_c4", 32'(gnt), 0);
    cyc();

    // Port 1 write then read back
    c = we_cnt;
    xact(1, 1'b1, 8'h10, 8'h3C, n);
    chk("C_we_cycles", 32'(we_cnt - c), 1);
    chk("C_ram_written", 32'(ram[8'h10]), 32'h3C);
    xact(1, 1'b0, 8'h10, 8'h00, n);

    // Simultaneous requests after reset: port 0 first, then strict alternation
    pulse_reset();
    ack_log.delete();
    na = 0; nb = 0;
    fork
      begin
        int t;
        for (int i = 0; i < 3; i++) begin
          xact(0, 1'b0, 8'(8'h30 + i), 8'h00, t);
          if (i == 0) na = t;
        end
      end
      begin
        int t;
        for (int i = 0; i < 3; i++) begin
          xact(1, 1'b0, 8'(8'hB0 + i), 8'h00, t);
          if (i == 0) nb = t;
        end
      end
    join
    chk("D_lat_p0_first", 32'(na), 3);
    chk("D_lat_p1_first", 32'(nb), 6);
    chk("D_ack_count", 32'(ack_log.size()), 6);
    for (int i = 0; i < ack_log.size(); i++)
      chk($sformatf("D_ack_order_%0d", i), 32'(ack_log[i]), 32'(i % 2));

    // req0 dropped during ACCESS; pending req1 gets the next grant
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h20;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h21;
    push_exp(0, 1'b0, 8'h20, 8'h00);
    push_exp(1, 1'b0, 8'h21, 8'h00);
    @(negedge clock);
    cyc();
    req0 = 1'b0;
    @(negedge clock);
    chk("E_gnt_access", 32'(gnt), 1);
    @(negedge clock);
    chk("E_ack0_done", 32'(ack0), 1);
    @(negedge clock);
    chk("E_gnt_idle", 32'(gnt), 0);
    @(negedge clock);
    chk("E_gnt_p1", 32'(gnt), 2);
    @(negedge clock);
    chk("E_ack1_done", 32'(ack1), 1);
    cyc();
    req1 = 1'b0;
    cyc();

    // Port 1 back-to-back reads of 0x00 and 0xFF
    fork
      begin
        xact(1, 1'b0, 8'h00, 8'h00, na);
        xact(1, 1'b0, 8'hFF, 8'h00, nb);
      end
      begin
        @(negedge clock);
        chk("F_gnt_idle0", 32'(gnt), 0);
        repeat (3) @(negedge clock);
        chk("F_gnt_idle1", 32'(gnt), 0);
      end
    join
    chk("F_lat_a", 32'(na), 3);
    chk("F_lat_b", 32'(nb), 3);

    // Randomized traffic on disjoint address halves
    fork
      rand_port(0, 40);
      rand_port(1, 40);
    join
    repeat (4) cyc();
    chk("exp0_drained", 32'(exp0_q.size()), 0);
    chk("exp1_drained", 32'(exp1_q.size()), 0);
    for (int i = 0; i < 256; i++)
      if (ram[i] !== ref_mem[i]) chk($sformatf("ram_final_%0h", i), 32'(ram[i]), 32'(ref_mem[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
